// File: rtl/whack_scorer.sv
// whack_scorer: classifies each new hole-button press against the current
// mole field as a hit or a miss. It keeps saturating score, miss and streak
// counters, and a per-hole mask of moles that have already been hit.
module whack_scorer #(
   parameter int NUM_HOLES = 18,
   parameter int SCORE_W   = 16,
   parameter int MISS_W    = 8,
   parameter int STREAK_W  = 8,
   parameter int POINTS    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 game_active,
   input  logic [NUM_HOLES-1:0] mole_positions,
   input  logic [NUM_HOLES-1:0] buttons,
   output logic [SCORE_W-1:0]   score,
   output logic [MISS_W-1:0]    misses,
   output logic [STREAK_W-1:0]  streak,
   output logic [NUM_HOLES-1:0] whacked,
   output logic                 hit_pulse,
   output logic                 miss_pulse
);

   // Width able to hold a count of 0..NUM_HOLES simultaneous events.
   localparam int CNT_W = $clog2(NUM_HOLES + 1);

   // Sum widths are chosen so that no sum can wrap before the clamp.
   localparam int SSUM_W = SCORE_W + CNT_W + 1;
   localparam int MSUM_W = ((MISS_W > CNT_W) ? MISS_W : CNT_W) + 1;
   localparam int KSUM_W = ((STREAK_W > CNT_W) ? STREAK_W : CNT_W) + 1;

   localparam logic [SSUM_W-1:0] SCORE_MAX  = SSUM_W'({SCORE_W{1'b1}});
   localparam logic [MSUM_W-1:0] MISS_MAX   = MSUM_W'({MISS_W{1'b1}});
   localparam logic [KSUM_W-1:0] STREAK_MAX = KSUM_W'({STREAK_W{1'b1}});
   localparam logic [SSUM_W-1:0] POINTS_EXT = SSUM_W'(POINTS);

   // Counts the set bits of a hole vector.
   function automatic logic [CNT_W-1:0] popcount(input logic [NUM_HOLES-1:0] v);
      logic [CNT_W-1:0] c;
      c = {CNT_W{1'b0}};
      for (int i = 0; i < NUM_HOLES; i++) begin
         c = c + CNT_W'(v[i]);
      end
      return c;
   endfunction

   logic [NUM_HOLES-1:0] btn_prev_r;
   logic [NUM_HOLES-1:0] mole_prev_r;
   logic                 act_prev_r;
   logic [SCORE_W-1:0]   score_r;
   logic [MISS_W-1:0]    misses_r;
   logic [STREAK_W-1:0]  streak_r;
   logic [NUM_HOLES-1:0] whacked_r;
   logic                 hit_pulse_r;
   logic                 miss_pulse_r;

   logic [NUM_HOLES-1:0] press_s;
   logic [NUM_HOLES-1:0] new_up_s;
   logic [NUM_HOLES-1:0] avail_s;
   logic [NUM_HOLES-1:0] hit_s;
   logic [NUM_HOLES-1:0] miss_s;
   logic [NUM_HOLES-1:0] whacked_nxt_s;
   logic                 round_start_s;
   logic [CNT_W-1:0]     nh_s;
   logic [CNT_W-1:0]     nm_s;
   logic [SSUM_W-1:0]    score_sum_s;
   logic [MSUM_W-1:0]    miss_sum_s;
   logic [KSUM_W-1:0]    streak_sum_s;
   logic [SCORE_W-1:0]   score_nxt_s;
   logic [MISS_W-1:0]    misses_nxt_s;
   logic [STREAK_W-1:0]  streak_nxt_s;

   // Press/mole classification. Next-state values are saturated here.
   always_comb begin
      round_start_s = game_active & ~act_prev_r;
      press_s       = buttons & ~btn_prev_r & {NUM_HOLES{game_active & act_prev_r}};
      new_up_s      = mole_positions & ~mole_prev_r;
      avail_s       = mole_positions & (new_up_s | ~whacked_r);
      hit_s         = press_s & avail_s;
      miss_s        = press_s & ~avail_s;
      // A hole is cleared when its mole is down, or when a fresh mole is up but has not been hit.
      whacked_nxt_s = mole_positions & (hit_s | (~new_up_s & whacked_r));
      nh_s          = popcount(hit_s);
      nm_s          = popcount(miss_s);

      score_sum_s  = SSUM_W'(score_r) + SSUM_W'(nh_s) * POINTS_EXT;
      miss_sum_s   = MSUM_W'(misses_r) + MSUM_W'(nm_s);
      streak_sum_s = KSUM_W'(streak_r) + KSUM_W'(nh_s);

      if (score_sum_s > SCORE_MAX) begin
         score_nxt_s = {SCORE_W{1'b1}};
      end else begin
         score_nxt_s = score_sum_s[SCORE_W-1:0];
      end

      if (miss_sum_s > MISS_MAX) begin
         misses_nxt_s = {MISS_W{1'b1}};
      end else begin
         misses_nxt_s = miss_sum_s[MISS_W-1:0];
      end

      if (nm_s != {CNT_W{1'b0}}) begin
         streak_nxt_s = {STREAK_W{1'b0}};
      end else if (streak_sum_s > STREAK_MAX) begin
         streak_nxt_s = {STREAK_W{1'b1}};
      end else begin
         streak_nxt_s = streak_sum_s[STREAK_W-1:0];
      end
   end

   // State update: history registers, counters, whacked mask and pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_prev_r   <= {NUM_HOLES{1'b1}};
         mole_prev_r  <= {NUM_HOLES{1'b0}};
         act_prev_r   <= 1'b0;
         score_r      <= {SCORE_W{1'b0}};
         misses_r     <= {MISS_W{1'b0}};
         streak_r     <= {STREAK_W{1'b0}};
         whacked_r    <= {NUM_HOLES{1'b0}};
         hit_pulse_r  <= 1'b0;
         miss_pulse_r <= 1'b0;
      end else begin
         btn_prev_r  <= buttons;
         mole_prev_r <= mole_positions;
         act_prev_r  <= game_active;
         if (round_start_s) begin
            score_r      <= {SCORE_W{1'b0}};
            misses_r     <= {MISS_W{1'b0}};
            streak_r     <= {STREAK_W{1'b0}};
            whacked_r    <= {NUM_HOLES{1'b0}};
            hit_pulse_r  <= 1'b0;
            miss_pulse_r <= 1'b0;
         end else begin
            score_r      <= score_nxt_s;
            misses_r     <= misses_nxt_s;
            streak_r     <= streak_nxt_s;
            whacked_r    <= whacked_nxt_s;
            hit_pulse_r  <= |hit_s;
            miss_pulse_r <= |miss_s;
         end
      end
   end

   assign score      = score_r;
   assign misses     = misses_r;
   assign streak     = streak_r;
   assign whacked    = whacked_r;
   assign hit_pulse  = hit_pulse_r;
   assign miss_pulse = miss_pulse_r;

endmodule

// File: tb/tb_whack_scorer.sv
// Directed, table-driven bench for whack_scorer, with hand-written
// sequences for mid-round reset and score saturation.
module tb_whack_scorer;

   logic        clk;
   logic        reset;
   logic        game_active;
   logic [17:0] mole_positions;
   logic [17:0] buttons;
   logic [15:0] score;
   logic [7:0]  misses;
   logic [7:0]  streak;
   logic [17:0] whacked;
   logic        hit_pulse;
   logic        miss_pulse;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        ga;
      logic [17:0] moles;
      logic [17:0] btn;
      logic [15:0] e_score;
      logic [7:0]  e_misses;
      logic [7:0]  e_streak;
      logic [17:0] e_whacked;
      logic        e_hp;
      logic        e_mp;
   } vec_t;

   vec_t vecs[$];

   whack_scorer dut (
      .clk            (clk),
      .reset          (reset),
      .game_active    (game_active),
      .mole_positions (mole_positions),
      .buttons        (buttons),
      .score          (score),
      .misses         (misses),
      .streak         (streak),
      .whacked        (whacked),
      .hit_pulse      (hit_pulse),
      .miss_pulse     (miss_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s %s: got %0h expected %0h", name, field, act, exp);
      end
   endtask

   task automatic check_all(input string name, input logic [15:0] es, input logic [7:0] em,
                            input logic [7:0] est, input logic [17:0] ew, input logic ehp, input logic emp);
      cmp(name, "score", 32'(score), 32'(es));
      cmp(name, "misses", 32'(misses), 32'(em));
      cmp(name, "streak", 32'(streak), 32'(est));
      cmp(name, "whacked", 32'(whacked), 32'(ew));
      cmp(name, "hit_pulse", 32'(hit_pulse), 32'(ehp));
      cmp(name, "miss_pulse", 32'(miss_pulse), 32'(emp));
   endtask

   // Drive inputs away from the active edge, then sample #1 after it.
   task automatic apply(input logic ga, input logic [17:0] m, input logic [17:0] b);
      @(negedge clk);
      game_active    = ga;
      mole_positions = m;
      buttons        = b;
      @(posedge clk);
      #1;
   endtask

   task automatic add_vec(input logic ga, input logic [17:0] m, input logic [17:0] b,
                          input logic [15:0] s, input logic [7:0] mi, input logic [7:0] st,
                          input logic [17:0] w, input logic hp, input logic mp);
      vec_t v;
      v.ga = ga; v.moles = m; v.btn = b;
      v.e_score = s; v.e_misses = mi; v.e_streak = st; v.e_whacked = w;
      v.e_hp = hp; v.e_mp = mp;
      vecs.push_back(v);
   endtask

   initial begin
      //       ga    moles      buttons    score   miss   strk   whacked    hp    mp
      add_vec(1'b0, 18'h00000, 18'h3FFFF, 16'd0, 8'd0, 8'd0, 18'h00000, 1'b0, 1'b0); // held past reset
      add_vec(1'b0, 18'h00000, 18'h00000, 16'd0, 8'd0, 8'd0, 18'h00000, 1'b0, 1'b0); // release
      add_vec(1'b1, 18'h00000, 18'h00000, 16'd0, 8'd0, 8'd0, 18'h00000, 1'b0, 1'b0); // round start
      add_vec(1'b1, 18'h00010, 18'h00000, 16'd0, 8'd0, 8'd0, 18'h00000, 1'b0, 1'b0); // mole 4 up
      add_vec(1'b1, 18'h00010, 18'h00010, 16'd1, 8'd0, 8'd1, 18'h00010, 1'b1, 1'b0); // hit 4
      add_vec(1'b1, 18'h00010, 18'h00000, 16'd1, 8'd0, 8'd1, 18'h00010, 1'b0, 1'b0);
      add_vec(1'b1, 18'h00010, 18'h00010, 16'd1, 8'd1, 8'd0, 18'h00010, 1'b0, 1'b1); // re-hit = miss
      add_vec(1'b1, 18'h00010, 18'h00000, 16'd1, 8'd1, 8'd0, 18'h00010, 1'b0, 1'b0);
      add_vec(1'b1, 18'h00000, 18'h00000, 16'd1, 8'd1, 8'd0, 18'h00000, 1'b0, 1'b0); // mole drops
      add_vec(1'b1, 18'h00884, 18'h00000, 16'd1, 8'd1, 8'd0, 18'h00000, 1'b0, 1'b0); // moles 2,7,11
      add_vec(1'b1, 18'h00884, 18'h00284, 16'd3, 8'd2, 8'd0, 18'h00084, 1'b1, 1'b1); // 2,7 hit; 9 miss
      add_vec(1'b1, 18'h00884, 18'h00000, 16'd3, 8'd2, 8'd0, 18'h00084, 1'b0, 1'b0);
      add_vec(1'b1, 18'h00884, 18'h00800, 16'd4, 8'd2, 8'd1, 18'h00884, 1'b1, 1'b0); // hit 11
      add_vec(1'b1, 18'h00000, 18'h00000, 16'd4, 8'd2, 8'd1, 18'h00000, 1'b0, 1'b0);
      add_vec(1'b1, 18'h00001, 18'h00001, 16'd5, 8'd2, 8'd2, 18'h00001, 1'b1, 1'b0); // hit on appear edge
      add_vec(1'b1, 18'h00000, 18'h00000, 16'd5, 8'd2, 8'd2, 18'h00000, 1'b0, 1'b0);
      add_vec(1'b0, 18'h00002, 18'h00000, 16'd5, 8'd2, 8'd2, 18'h00000, 1'b0, 1'b0); // inactive
      add_vec(1'b0, 18'h00002, 18'h00002, 16'd5, 8'd2, 8'd2, 18'h00000, 1'b0, 1'b0); // ignored press
      add_vec(1'b0, 18'h00000, 18'h00000, 16'd5, 8'd2, 8'd2, 18'h00000, 1'b0, 1'b0);
      add_vec(1'b1, 18'h00002, 18'h00002, 16'd0, 8'd0, 8'd0, 18'h00000, 1'b0, 1'b0); // restart + press
      add_vec(1'b1, 18'h00002, 18'h00002, 16'd0, 8'd0, 8'd0, 18'h00000, 1'b0, 1'b0); // held, no edge
      add_vec(1'b1, 18'h00002, 18'h00000, 16'd0, 8'd0, 8'd0, 18'h00000, 1'b0, 1'b0);
      add_vec(1'b1, 18'h00002, 18'h00002, 16'd1, 8'd0, 8'd1, 18'h00002, 1'b1, 1'b0); // hit 1

      // Reset with every button held.
      reset          = 1'b1;
      game_active    = 1'b0;
      mole_positions = 18'h00000;
      buttons        = 18'h3FFFF;
      repeat (3) @(posedge clk);
      #1;
      check_all("reset", 16'd0, 8'd0, 8'd0, 18'h00000, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].ga, vecs[i].moles, vecs[i].btn);
         check_all($sformatf("vec%0d", i), vecs[i].e_score, vecs[i].e_misses, vecs[i].e_streak,
                   vecs[i].e_whacked, vecs[i].e_hp, vecs[i].e_mp);
      end

      // Mid-round reset overrides a live hit.
      @(negedge clk);
      reset          = 1'b1;
      game_active    = 1'b1;
      mole_positions = 18'h00008;
      buttons        = 18'h00008;
      @(posedge clk);
      #1;
      check_all("midreset", 16'd0, 8'd0, 8'd0, 18'h00000, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      // Saturation: start a round, then 3640 rounds of 18 hits plus one of 14, which gives 0xFFFE.
      apply(1'b0, 18'h00000, 18'h00000);
      apply(1'b1, 18'h00000, 18'h00000);
      apply(1'b1, 18'h3FFFF, 18'h3FFFF);
      check_all("sat_first", 16'd18, 8'd0, 8'd18, 18'h3FFFF, 1'b1, 1'b0);
      apply(1'b1, 18'h00000, 18'h00000);
      for (int i = 1; i < 3640; i++) begin
         apply(1'b1, 18'h3FFFF, 18'h3FFFF);
         apply(1'b1, 18'h00000, 18'h00000);
      end
      apply(1'b1, 18'h03FFF, 18'h03FFF);
      apply(1'b1, 18'h00000, 18'h00000);
      check_all("sat_preload", 16'hFFFE, 8'd0, 8'hFF, 18'h00000, 1'b0, 1'b0);
      apply(1'b1, 18'h00001, 18'h00001);
      check_all("sat_one", 16'hFFFF, 8'd0, 8'hFF, 18'h00001, 1'b1, 1'b0);
      apply(1'b1, 18'h00000, 18'h00000);
      apply(1'b1, 18'h00003, 18'h00003);
      check_all("sat_clamp", 16'hFFFF, 8'd0, 8'hFF, 18'h00003, 1'b1, 1'b0);
      apply(1'b1, 18'h00003, 18'h00000);
      check_all("sat_hold", 16'hFFFF, 8'd0, 8'hFF, 18'h00003, 1'b0, 1'b0);

      // Round restart at the top of the range.
      apply(1'b0, 18'h00000, 18'h00000);
      apply(1'b1, 18'h00000, 18'h00000);
      check_all("restart", 16'd0, 8'd0, 8'd0, 18'h00000, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
